// File: rtl/coconut_pkg.sv
// coconut_pkg: shared constants and the FSM state type for the coconut
// search engine.
//   WIDTH      default width of every count and share
//   N_SAILORS  number of night rounds (one per sailor)
//   N_ROUNDS   night rounds plus the morning round
//   DIVISOR    every round divides the pile by this value
package coconut_pkg;
  localparam int WIDTH     = 32;
  localparam int N_SAILORS = 5;
  localparam int N_ROUNDS  = 6;
  localparam int DIVISOR   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/coconut_search_if.sv
// coconut_search_if: request/result bundle of the coconut search engine.
//   master: drives start, start_count, limit; observes status and results
//   slave : the search engine side
interface coconut_search_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] start_count;
  logic [WIDTH-1:0] limit;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] coconuts;
  logic [WIDTH-1:0] m1;
  logic [WIDTH-1:0] m2;
  logic [WIDTH-1:0] m3;
  logic [WIDTH-1:0] m4;
  logic [WIDTH-1:0] m5;
  logic [WIDTH-1:0] morning;
  logic [WIDTH-1:0] monkey;
  logic [WIDTH-1:0] total;
  logic             total_err;

  modport master (
    output start, start_count, limit,
    input  busy, done, found, cand, coconuts, m1, m2, m3, m4, m5,
           morning, monkey, total, total_err
  );

  modport slave (
    input  start, start_count, limit,
    output busy, done, found, cand, coconuts, m1, m2, m3, m4, m5,
           morning, monkey, total, total_err
  );
endinterface

// File: rtl/coconut_round.sv
// coconut_round: one divide-by-five round, purely combinational.
//   pile      in : pile at the start of the round
//   ok        out: pile leaves remainder 1 (one coconut for the monkey)
//   share     out: (pile-1)/5, the share taken this round
//   next_pile out: pile-1-share, what is left for the next round
// For pile 0 the share/next_pile terms wrap, but ok is 0 so they are unused.
import coconut_pkg::*;

module coconut_round #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pile,
  output logic             ok,
  output logic [WIDTH-1:0] share,
  output logic [WIDTH-1:0] next_pile
);
  localparam logic [WIDTH-1:0] ONE_C = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DIV_C = WIDTH'(DIVISOR);

  logic [WIDTH-1:0] rem_s;

  assign rem_s     = pile % DIV_C;
  assign ok        = (rem_s == ONE_C);
  assign share     = (pile - ONE_C) / DIV_C;
  assign next_pile = pile - ONE_C - share;
endmodule

// File: rtl/coconut_search.sv
// coconut_search: walks candidate piles upward from start_count and stops at
// the first pile where all five night rounds and the morning round leave
// remainder 1, or after testing limit.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): start/start_count/limit in; busy, done, found, cand and the
//                registered results (coconuts, m1..m5, morning, monkey,
//                total, total_err) out
// Optional feature: define COCONUT_TOTAL_CHECK_EN to build the total adder
// and the total_err flag; otherwise total and total_err are tied to 0.
import coconut_pkg::*;

module coconut_search #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  coconut_search_if.slave bus
);
  localparam logic [WIDTH-1:0] ONE_C    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MONKEY_C = WIDTH'(N_ROUNDS);
  localparam logic [2:0]       LAST_R_C = 3'(N_SAILORS);

  state_t           state_r;
  logic [WIDTH-1:0] cand_r;
  logic [WIDTH-1:0] pile_r;
  logic [2:0]       rnd_r;
  logic [WIDTH-1:0] share_r [N_SAILORS];
  logic [WIDTH-1:0] m_r     [N_SAILORS];
  logic             busy_r;
  logic             done_r;
  logic             found_r;
  logic [WIDTH-1:0] coconuts_r;
  logic [WIDTH-1:0] morning_r;
  logic [WIDTH-1:0] monkey_r;

  logic             ok_s;
  logic [WIDTH-1:0] share_s;
  logic [WIDTH-1:0] next_pile_s;
  logic             start_acc_s;
  logic             final_pass_s;

  coconut_round #(.WIDTH(WIDTH)) u_round (
    .pile      (pile_r),
    .ok        (ok_s),
    .share     (share_s),
    .next_pile (next_pile_s)
  );

  assign start_acc_s  = (state_r == ST_IDLE) && bus.start;
  assign final_pass_s = (state_r == ST_ROUND) && ok_s && (rnd_r == LAST_R_C);

  // Search FSM: candidate/pile stepping, share capture and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cand_r     <= '0;
      pile_r     <= '0;
      rnd_r      <= 3'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      found_r    <= 1'b0;
      coconuts_r <= '0;
      morning_r  <= '0;
      monkey_r   <= '0;
      for (int i = 0; i < N_SAILORS; i++) begin
        share_r[i] <= '0;
        m_r[i]     <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            cand_r     <= bus.start_count;
            pile_r     <= bus.start_count;
            rnd_r      <= 3'd0;
            found_r    <= 1'b0;
            busy_r     <= 1'b1;
            // Results from a previous search are dropped on a new start.
            coconuts_r <= '0;
            morning_r  <= '0;
            monkey_r   <= '0;
            for (int i = 0; i < N_SAILORS; i++) begin
              m_r[i] <= '0;
            end
            state_r    <= ST_ROUND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ROUND: begin
          if (ok_s) begin
            if (rnd_r != LAST_R_C) begin
              share_r[rnd_r] <= share_s;
              pile_r         <= next_pile_s;
              rnd_r          <= rnd_r + 3'd1;
            end else begin
              // Morning round passed: each sailor adds the morning share.
              for (int i = 0; i < N_SAILORS; i++) begin
                m_r[i] <= share_r[i] + share_s;
              end
              coconuts_r <= cand_r;
              morning_r  <= pile_r;
              monkey_r   <= MONKEY_C;
              found_r    <= 1'b1;
              busy_r     <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end
          end else if (cand_r < bus.limit) begin
            cand_r <= cand_r + ONE_C;
            pile_r <= cand_r + ONE_C;
            rnd_r  <= 3'd0;
          end else begin
            found_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef COCONUT_TOTAL_CHECK_EN
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] total_r;
  logic             total_err_r;

  // Sum of the per-sailor totals being written this cycle plus the monkey.
  always_comb begin
    sum_s = MONKEY_C;
    for (int i = 0; i < N_SAILORS; i++) begin
      sum_s = sum_s + share_r[i] + share_s;
    end
  end

  // Total and consistency flag, captured when a solution is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_r     <= '0;
      total_err_r <= 1'b0;
    end else if (start_acc_s) begin
      total_r     <= '0;
      total_err_r <= 1'b0;
    end else if (final_pass_s) begin
      total_r     <= sum_s;
      total_err_r <= (sum_s != cand_r);
    end else begin
      total_r     <= total_r;
      total_err_r <= total_err_r;
    end
  end

  assign bus.total     = total_r;
  assign bus.total_err = total_err_r;
`else
  assign bus.total     = '0;
  assign bus.total_err = 1'b0;
`endif

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.found    = found_r;
  assign bus.cand     = cand_r;
  assign bus.coconuts = coconuts_r;
  assign bus.morning  = morning_r;
  assign bus.monkey   = monkey_r;
  assign bus.m1       = m_r[0];
  assign bus.m2       = m_r[1];
  assign bus.m3       = m_r[2];
  assign bus.m4       = m_r[3];
  assign bus.m5       = m_r[4];
endmodule

// File: tb/tb_coconut_search.sv
// tb_coconut_search: directed and randomized runs of coconut_search checked
// against a behavioural model of the sailors-and-monkey puzzle.
module tb_coconut_search;
  localparam int MAX_WAIT = 60000;

  logic clk;
  logic rst_n;

  coconut_search_if bus ();

  coconut_search dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Expected values produced by the model.
  bit              e_found;
  longint unsigned e_cand;
  longint unsigned e_coc;
  longint unsigned e_morn;
  longint unsigned e_monkey;
  longint unsigned e_total;
  longint unsigned e_m [5];
  int              e_cycles;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Puzzle model: try each pile; five sailors in turn give one coconut to the
  // monkey and hide a fifth of the rest, then the morning split does the same.
  // Each attempted round costs one clock.
  task automatic model(input longint unsigned sc, input longint unsigned lim);
    longint unsigned c, p, morn;
    longint unsigned s [6];
    bit ok;
    e_found = 0; e_coc = 0; e_morn = 0; e_monkey = 0; e_total = 0;
    e_cycles = 0;
    for (int i = 0; i < 5; i++) e_m[i] = 0;
    c = sc;
    morn = 0;
    forever begin
      p  = c;
      ok = 1;
      for (int k = 0; k < 6; k++) begin
        e_cycles++;
        if (p % 5 != 1) begin
          ok = 0;
          break;
        end
        if (k == 5) morn = p;
        s[k] = (p - 1) / 5;
        p    = p - 1 - s[k];
      end
      if (ok) begin
        e_found  = 1;
        e_coc    = c;
        e_morn   = morn;
        e_monkey = 6;
        for (int i = 0; i < 5; i++) e_m[i] = s[i] + s[5];
        break;
      end
      if (c >= lim) break;
      c++;
    end
    e_cand = c;
`ifdef COCONUT_TOTAL_CHECK_EN
    if (e_found) e_total = e_m[0] + e_m[1] + e_m[2] + e_m[3] + e_m[4] + e_monkey;
`endif
  endtask

  task automatic run(input string tag, input longint unsigned sc,
                     input longint unsigned lim, input bit inject,
                     input bit step_chk);
    int k;
    int bad;
    bit seen;
    logic [31:0] prev;
    model(sc, lim);
    @(negedge clk);
    bus.start_count = sc[31:0];
    bus.limit       = lim[31:0];
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_val({tag, ".busy_go"}, bus.busy, 1);
    prev = bus.cand;
    bad  = 0;
    k    = 0;
    seen = 0;
    while (!seen && k < MAX_WAIT) begin
      if (inject && k == 2) begin
        bus.start       = 1'b1;
        bus.start_count = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      k++;
      if (bus.cand != prev && bus.cand != prev + 32'd1) bad++;
      prev = bus.cand;
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    check_val({tag, ".done_seen"}, seen, 1);
    check_val({tag, ".latency"}, k, e_cycles);
    check_val({tag, ".busy_done"}, bus.busy, 0);
    check_val({tag, ".found"}, bus.found, e_found);
    check_val({tag, ".cand"}, bus.cand, e_cand);
    check_val({tag, ".coconuts"}, bus.coconuts, e_coc);
    check_val({tag, ".morning"}, bus.morning, e_morn);
    check_val({tag, ".monkey"}, bus.monkey, e_monkey);
    check_val({tag, ".m1"}, bus.m1, e_m[0]);
    check_val({tag, ".m2"}, bus.m2, e_m[1]);
    check_val({tag, ".m3"}, bus.m3, e_m[2]);
    check_val({tag, ".m4"}, bus.m4, e_m[3]);
    check_val({tag, ".m5"}, bus.m5, e_m[4]);
    check_val({tag, ".total"}, bus.total, e_total);
    check_val({tag, ".total_err"}, bus.total_err, 0);
    if (step_chk) check_val({tag, ".cand_step"}, bad, 0);
    @(posedge clk);
    #1;
    check_val({tag, ".done_pulse"}, bus.done, 0);
    check_val({tag, ".idle_busy"}, bus.busy, 0);
    check_val({tag, ".held_found"}, bus.found, e_found);
  endtask

  initial begin
    int done_bad;
    int mode;
    longint unsigned sc, lim;
    n_checks = 0;
    n_errors = 0;
    rst_n           = 1'b0;
    bus.start       = 1'b0;
    bus.start_count = 32'd0;
    bus.limit       = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst.busy", bus.busy, 0);
    check_val("rst.done", bus.done, 0);
    check_val("rst.found", bus.found, 0);
    check_val("rst.cand", bus.cand, 0);
    check_val("rst.coconuts", bus.coconuts, 0);
    check_val("rst.m1", bus.m1, 0);
    check_val("rst.monkey", bus.monkey, 0);
    check_val("rst.total", bus.total, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    run("known", 64'd15621, 64'd15621, 0, 0);
    check_val("known.lat_abs", e_cycles, 6);
    check_val("known.m1_abs", bus.m1, 4147);
    check_val("known.morning_abs", bus.morning, 5116);
    run("no_sol", 64'd15622, 64'd16000, 0, 1);
    run("known_inj", 64'd15621, 64'd15621, 1, 0);
    run("sc_gt_lim_pass", 64'd15621, 64'd0, 0, 0);
    run("sc_gt_lim_fail", 64'd15620, 64'd0, 0, 0);
    check_val("sc_gt_lim_fail.lat_abs", e_cycles, 1);

    // Reset mid-run.
    @(negedge clk);
    bus.start_count = 32'd15621;
    bus.limit       = 32'd15621;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst.busy", bus.busy, 0);
    check_val("midrst.cand", bus.cand, 0);
    check_val("midrst.found", bus.found, 0);
    done_bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) done_bad++;
      if (i == 3) rst_n = 1'b1;
    end
    check_val("midrst.no_done", done_bad, 0);
    check_val("midrst.idle", bus.busy, 0);
    run("restart", 64'd15621, 64'd15621, 0, 0);

    // Full search from zero.
    run("full", 64'd0, 64'd20000, 0, 1);
    check_val("full.coconuts_abs", bus.coconuts, 15621);

    // Randomized ranges.
    for (int it = 0; it < 8; it++) begin
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        sc  = $urandom_range(15400, 15621);
        lim = sc + $urandom_range(0, 300);
      end else if (mode == 1) begin
        sc  = $urandom_range(0, 40000);
        lim = sc + $urandom_range(0, 200);
      end else begin
        sc  = $urandom_range(1, 40000);
        lim = $urandom_range(0, 32'(sc - 1));
      end
      run($sformatf("rnd%0d", it), sc, lim, 0, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
